lfsr_seed_sequencer: RTL and testbench
======================================

Name: lfsr_seed_sequencer

Overview:
- Controller for the 347-bit, 13-steps-per-enable scrambler LFSR.
- Accepts a seed as a stream of 32-bit words and loads it into the LFSR seed registers (write strobes at addresses 0x091..0x09B).
- Then issues a counted burst of LFSR enable pulses under valid/ready backpressure, so each scrambler block is delivered downstream exactly once.
- Sits between the host/config path and the LFSR; the LFSR's dout goes directly to the consumer, qualified by blk_valid.

Parameters:
- NUM_WORDS, 11, number of seed words per load.
- BASE_ADDR, 12'h091, LFSR address of seed word 0.
- CNT_W, 16, width of the block counter.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin load+run; sampled only in IDLE.
- abort  in  1  synchronous cancel; takes effect in any state.
- blk_count  in  CNT_W  number of LFSR steps to run; sampled with start.
- seed_valid  in  1  seed word available.
- seed_data  in  32  seed word. Word 0 maps to LFSR bits 31:0; word 10 maps to bits 346:320, upper 5 bits are don't-care.
- seed_ready  out  1  sequencer accepts a seed word.
- lfsr_write  out  1  LFSR write strobe.
- lfsr_addr  out  12  LFSR address.
- lfsr_din  out  32  LFSR write data.
- lfsr_enable  out  1  LFSR step request.
- ds_ready  in  1  consumer accepts the current LFSR dout.
- blk_valid  out  1  LFSR dout holds a fresh, not-yet-accepted block.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at normal completion.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; word_idx=0; rem=0.
  - blk_valid=0, done=0, busy=0.
  - Combinational outputs reset-quiet: seed_ready=0, lfsr_write=0, lfsr_enable=0, lfsr_addr=BASE_ADDR, lfsr_din=0.
- States: IDLE, LOAD, RUN, DRAIN.
- IDLE:
  - start=1 and blk_count!=0: latch rem=blk_count and go to LOAD.
  - start=1 and blk_count==0: pulse done the next cycle and stay in IDLE.
- LOAD:
  - seed_ready=1.
  - When seed_valid&seed_ready (same cycle, combinational): lfsr_write=1, lfsr_addr=BASE_ADDR+word_idx, lfsr_din=seed_data.
  - Each accepted word increments word_idx.
  - Acceptance of word NUM_WORDS-1: word_idx clears to 0 and state moves to RUN.
  - seed_valid low: no write; a stall of any length is legal.
  - Outside LOAD, lfsr_write=0, lfsr_din=0, lfsr_addr=BASE_ADDR.
- RUN:
  - lfsr_enable = (rem!=0) & (!blk_valid | ds_ready), combinational.
  - Each enable decrements rem.
  - The LFSR updates dout at the same edge that registers blk_valid=1, so dout and blk_valid align with zero offset.
  - blk_valid next value: 1 if lfsr_enable; else 0 if ds_ready; else hold.
  - Back-to-back steps give one block per cycle while ds_ready=1.
  - Move to DRAIN on the edge where rem reaches 0.
- DRAIN:
  - lfsr_enable=0.
  - When blk_valid=0, or blk_valid&ds_ready: pulse done, blk_valid goes to 0, state goes to IDLE.
- lfsr_write and lfsr_enable are never high together; LOAD and RUN are mutually exclusive.
- start while busy=1 is ignored. blk_count is not resampled after start.
- abort=1 in any state: next state IDLE, blk_valid=0, word_idx=0, rem=0, no done pulse.
  - LFSR contents after abort are undefined (partial seed).
  - abort has priority over start in the same cycle.
- Reset mid-operation: immediate return to reset values; the LFSR is reset by its own reset.
- rem is CNT_W bits; maximum burst is 2^CNT_W-1. The counter does not wrap.

Test Plan:
- Seed load:
  - Stimulus: start with blk_count=1; seed_valid held high with words 0x00000001..0x0000000B.
  - Response: 11 consecutive writes at addr 0x091..0x09B with matching din; seed_ready drops after the 11th.
  - Then one enable, blk_valid high the next cycle, done after acceptance.
- Gapped seed:
  - Stimulus: seed_valid toggled 1-0-1.
  - Response: writes only on valid cycles; addresses remain contiguous 0x091..0x09B; no enable until all 11 are accepted.
- Burst with ds_ready=1:
  - Stimulus: blk_count=4.
  - Response: lfsr_enable high 4 consecutive cycles; blk_valid high 4 cycles; done exactly 1 cycle after the last block is accepted; busy low the following cycle.
- Backpressure:
  - Stimulus: blk_count=3; ds_ready low for 3 cycles after the first block.
  - Response: enable held low and blk_valid held high during the stall; exactly 3 enables total; dout unchanged while stalled.
- Zero count:
  - Stimulus: start with blk_count=0.
  - Response: no writes, no enables; done pulse 1 cycle later; busy stays 0.
- Abort:
  - Stimulus: abort after 5 seed words; a later case asserts abort mid-RUN with blk_valid=1.
  - Response: IDLE next cycle; seed_ready=0, blk_valid=0, no done.
  - A subsequent start performs a full 11-word load starting at 0x091.

Source files
------------

// File: rtl/lfsr_seed_sequencer.sv
// lfsr_seed_sequencer: loads a multi-word seed into the scrambler LFSR, then
// issues a counted burst of LFSR steps under valid/ready backpressure so that
// every scrambler block is handed to the consumer exactly once.
//
// Handshakes:
//   seed path : a word transfers on a cycle where seed_valid && seed_ready.
//   block path: blk_valid qualifies the LFSR dout; the block is consumed on a
//               cycle where blk_valid && ds_ready. A new step is only issued
//               when the current block is absent or being consumed.
module lfsr_seed_sequencer #(
  parameter int          NUM_WORDS = 11,
  parameter logic [11:0] BASE_ADDR = 12'h091,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] blk_count,
  input  logic             seed_valid,
  input  logic [31:0]      seed_data,
  output logic             seed_ready,
  output logic             lfsr_write,
  output logic [11:0]      lfsr_addr,
  output logic [31:0]      lfsr_din,
  output logic             lfsr_enable,
  input  logic             ds_ready,
  output logic             blk_valid,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_word_idx;
  logic [CNT_W-1:0] r_rem;
  logic             r_blk_valid;
  logic             r_done;

  state_t           w_state_nxt;
  logic [IDX_W-1:0] w_word_idx_nxt;
  logic [CNT_W-1:0] w_rem_nxt;
  logic             w_blk_valid_nxt;
  logic             w_done_nxt;
  logic             w_fire;
  logic             w_step;

  // Datapath strobes toward the LFSR; quiet (base address, zero data) unless
  // a seed word is actually transferring.
  always_comb begin
    w_fire      = (r_state == S_LOAD) && seed_valid;
    w_step      = (r_state == S_RUN) && (r_rem != '0) && (!r_blk_valid || ds_ready);
    seed_ready  = (r_state == S_LOAD);
    lfsr_write  = w_fire;
    lfsr_addr   = w_fire ? (BASE_ADDR + 12'(r_word_idx)) : BASE_ADDR;
    lfsr_din    = w_fire ? seed_data : 32'h0;
    lfsr_enable = w_step;
    blk_valid   = r_blk_valid;
    busy        = (r_state != S_IDLE);
    done        = r_done;
    dbg_state   = r_state;
  end

  // Next-state logic; abort overrides everything, including a same-cycle start.
  always_comb begin
    w_state_nxt     = r_state;
    w_word_idx_nxt  = r_word_idx;
    w_rem_nxt       = r_rem;
    w_blk_valid_nxt = r_blk_valid;
    w_done_nxt      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (blk_count != '0) begin
            w_rem_nxt   = blk_count;
            w_state_nxt = S_LOAD;
          end else begin
            w_done_nxt = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (w_fire) begin
          if (r_word_idx == IDX_W'(NUM_WORDS - 1)) begin
            w_word_idx_nxt = '0;
            w_state_nxt    = S_RUN;
          end else begin
            w_word_idx_nxt = r_word_idx + IDX_W'(1);
          end
        end
      end
      S_RUN: begin
        if (w_step) begin
          // dout updates on this same edge, so blk_valid rises with it.
          w_rem_nxt       = r_rem - CNT_W'(1);
          w_blk_valid_nxt = 1'b1;
          if (r_rem == CNT_W'(1)) begin
            w_state_nxt = S_DRAIN;
          end
        end else if (ds_ready) begin
          w_blk_valid_nxt = 1'b0;
        end
      end
      S_DRAIN: begin
        if (!r_blk_valid || ds_ready) begin
          w_blk_valid_nxt = 1'b0;
          w_done_nxt      = 1'b1;
          w_state_nxt     = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (abort) begin
      w_state_nxt     = S_IDLE;
      w_word_idx_nxt  = '0;
      w_rem_nxt       = '0;
      w_blk_valid_nxt = 1'b0;
      w_done_nxt      = 1'b0;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_word_idx  <= '0;
      r_rem       <= '0;
      r_blk_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_word_idx  <= w_word_idx_nxt;
      r_rem       <= w_rem_nxt;
      r_blk_valid <= w_blk_valid_nxt;
      r_done      <= w_done_nxt;
    end
  end

endmodule

// File: tb/tb_lfsr_seed_sequencer.sv
// Directed bench for lfsr_seed_sequencer: seed load, gapped seed, burst,
// backpressure, zero count and abort scenarios with hand-derived expectations.
module tb_lfsr_seed_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] blk_count;
  logic        seed_valid;
  logic [31:0] seed_data;
  logic        seed_ready;
  logic        lfsr_write;
  logic [11:0] lfsr_addr;
  logic [31:0] lfsr_din;
  logic        lfsr_enable;
  logic        ds_ready;
  logic        blk_valid;
  logic        busy;
  logic        done;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  lfsr_seed_sequencer #(
    .NUM_WORDS(11),
    .BASE_ADDR(12'h091),
    .CNT_W    (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .blk_count  (blk_count),
    .seed_valid (seed_valid),
    .seed_data  (seed_data),
    .seed_ready (seed_ready),
    .lfsr_write (lfsr_write),
    .lfsr_addr  (lfsr_addr),
    .lfsr_din   (lfsr_din),
    .lfsr_enable(lfsr_enable),
    .ds_ready   (ds_ready),
    .blk_valid  (blk_valid),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Raise start for exactly one clock edge.
  task automatic do_start(input logic [15:0] cnt);
    @(negedge clk);
    start     = 1'b1;
    blk_count = cnt;
    @(posedge clk);
    #1 start  = 1'b0;
  endtask

  // Feed n seed words (base+i); optionally idle every other cycle.
  task automatic load_words(input logic [31:0] base, input bit gapped, input int n);
    int i   = 0;
    int cyc = 0;
    while (i < n) begin
      @(negedge clk);
      if (gapped && (cyc % 2 == 1)) begin
        seed_valid = 1'b0;
        seed_data  = 32'hDEAD_BEEF;
        #1;
        chk("gap_write", 32'(lfsr_write), 32'd0);
        chk("gap_enable", 32'(lfsr_enable), 32'd0);
        chk("gap_ready", 32'(seed_ready), 32'd1);
      end else begin
        seed_valid = 1'b1;
        seed_data  = base + 32'(i);
        #1;
        chk("load_write", 32'(lfsr_write), 32'd1);
        chk("load_addr", 32'(lfsr_addr), 32'h091 + 32'(i));
        chk("load_din", 32'(lfsr_din), base + 32'(i));
        chk("load_enable", 32'(lfsr_enable), 32'd0);
        i++;
      end
      cyc++;
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; blk_count = '0;
    seed_valid = 1'b0; seed_data = '0; ds_ready = 1'b1;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(dbg_state), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bv", 32'(blk_valid), 32'd0);
    chk("rst_ready", 32'(seed_ready), 32'd0);
    chk("rst_write", 32'(lfsr_write), 32'd0);
    chk("rst_enable", 32'(lfsr_enable), 32'd0);
    chk("rst_addr", 32'(lfsr_addr), 32'h091);
    chk("rst_din", lfsr_din, 32'd0);
    rst_n = 1'b1;

    // Seed load, blk_count=1.
    do_start(16'd1);
    load_words(32'h1, 1'b0, 11);
    @(negedge clk);              // RUN, rem=1, blk_valid=0
    seed_valid = 1'b1;           // still offered, must not be taken
    #1;
    chk("s1_ready_drop", 32'(seed_ready), 32'd0);
    chk("s1_no_write", 32'(lfsr_write), 32'd0);
    chk("s1_enable", 32'(lfsr_enable), 32'd1);
    @(negedge clk);              // DRAIN, block present
    seed_valid = 1'b0;
    chk("s1_bv", 32'(blk_valid), 32'd1);
    chk("s1_en_off", 32'(lfsr_enable), 32'd0);
    chk("s1_done_early", 32'(done), 32'd0);
    @(negedge clk);
    chk("s1_done", 32'(done), 32'd1);
    chk("s1_busy", 32'(busy), 32'd0);
    chk("s1_bv_clr", 32'(blk_valid), 32'd0);
    @(negedge clk);
    chk("s1_done_pulse", 32'(done), 32'd0);

    // Gapped seed, blk_count=2.
    do_start(16'd2);
    load_words(32'h100, 1'b1, 11);
    @(negedge clk);
    seed_valid = 1'b0;
    #1 chk("g_en0", 32'(lfsr_enable), 32'd1);
    @(negedge clk);
    #1 chk("g_en1", 32'(lfsr_enable), 32'd1);
    @(negedge clk);
    chk("g_drain_bv", 32'(blk_valid), 32'd1);
    @(negedge clk);
    chk("g_done", 32'(done), 32'd1);

    // Burst of 4 with ds_ready=1.
    do_start(16'd4);
    load_words(32'hA000_0000, 1'b0, 11);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      seed_valid = 1'b0;
      #1;
      chk("b_enable", 32'(lfsr_enable), 32'd1);
      chk("b_bv", 32'(blk_valid), (k > 0) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    #1;
    chk("b_last_bv", 32'(blk_valid), 32'd1);
    chk("b_en_off", 32'(lfsr_enable), 32'd0);
    chk("b_no_done", 32'(done), 32'd0);
    @(negedge clk);
    chk("b_done", 32'(done), 32'd1);
    chk("b_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("b_done_pulse", 32'(done), 32'd0);

    // Backpressure, blk_count=3, ds_ready low for 3 cycles after first block.
    do_start(16'd3);
    load_words(32'h5000, 1'b0, 11);
    @(negedge clk);
    seed_valid = 1'b0;
    #1 chk("bp_en_first", 32'(lfsr_enable), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      ds_ready = 1'b0;
      #1;
      chk("bp_stall_en", 32'(lfsr_enable), 32'd0);
      chk("bp_stall_bv", 32'(blk_valid), 32'd1);
    end
    @(negedge clk);
    ds_ready = 1'b1;
    #1 chk("bp_en_2", 32'(lfsr_enable), 32'd1);
    @(negedge clk);
    #1 chk("bp_en_3", 32'(lfsr_enable), 32'd1);
    @(negedge clk);
    #1;
    chk("bp_drain_en", 32'(lfsr_enable), 32'd0);
    chk("bp_drain_bv", 32'(blk_valid), 32'd1);
    @(negedge clk);
    chk("bp_done", 32'(done), 32'd1);

    // Zero count.
    @(negedge clk);
    start = 1'b1; blk_count = 16'd0;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("z_done", 32'(done), 32'd1);
    chk("z_busy", 32'(busy), 32'd0);
    chk("z_write", 32'(lfsr_write), 32'd0);
    chk("z_enable", 32'(lfsr_enable), 32'd0);
    @(negedge clk);
    chk("z_done_pulse", 32'(done), 32'd0);

    // Abort after 5 seed words.
    do_start(16'd2);
    load_words(32'h7700, 1'b0, 5);
    @(negedge clk);
    seed_valid = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("a1_state", 32'(dbg_state), 32'd0);
    chk("a1_ready", 32'(seed_ready), 32'd0);
    chk("a1_bv", 32'(blk_valid), 32'd0);
    chk("a1_done", 32'(done), 32'd0);
    @(negedge clk);
    chk("a1_done_later", 32'(done), 32'd0);

    // Full reload after abort, then abort mid-RUN with blk_valid=1.
    do_start(16'd3);
    load_words(32'h9900, 1'b0, 11);
    @(negedge clk);
    seed_valid = 1'b0;
    #1 chk("a2_en", 32'(lfsr_enable), 32'd1);
    @(negedge clk);
    ds_ready = 1'b0;
    abort = 1'b1;
    #1 chk("a2_bv_before", 32'(blk_valid), 32'd1);
    @(negedge clk);
    abort = 1'b0;
    ds_ready = 1'b1;
    #1;
    chk("a2_state", 32'(dbg_state), 32'd0);
    chk("a2_bv", 32'(blk_valid), 32'd0);
    chk("a2_done", 32'(done), 32'd0);
    chk("a2_busy", 32'(busy), 32'd0);
    chk("a2_enable", 32'(lfsr_enable), 32'd0);
    @(negedge clk);
    chk("a2_done_later", 32'(done), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
